// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle (five channels) shared by a register-file slave and its master.
// Clock and reset are kept outside the interface.
interface axi_lite_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave terminating the bus in NUM_REGS registers with byte strobes,
// read-only hardware-sourced registers and SLVERR for out-of-range / read-only writes.
module axi_lite_regfile #(
    parameter int                              ADDR_WIDTH = 32,
    parameter int                              DATA_WIDTH = 32,
    parameter int                              NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]             RO_MASK    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VAL  = '0
) (
    input  logic                           aclk,
    input  logic                           areset,
    axi_lite_regfile_if.slave              s,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int         STRB_W      = DATA_WIDTH / 8;
    localparam int         OFFS        = $clog2(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_DATA } r_state_e;

    w_state_e              w_state_q;
    r_state_e              r_state_q;
    logic                  aw_held_q, w_held_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic [NUM_REGS-1:0]   wr_pulse_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic [ADDR_WIDTH-1:0] w_idx, r_idx;
    logic                  commit;
    logic [NUM_REGS-1:0]   w_hit;
    logic [NUM_REGS-1:0]   wr_pulse_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [1:0]            rresp_d;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        w_idx   = aw_addr_q >> OFFS;
        r_idx   = s.araddr >> OFFS;
        commit  = (w_state_q == W_IDLE) && aw_held_q && w_held_q;
        w_hit   = '0;
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == ADDR_WIDTH'(i) && !RO_MASK[i]) w_hit[i] = 1'b1;
            if (r_idx == ADDR_WIDTH'(i)) begin
                rresp_d = RESP_OKAY;
                rdata_d = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end
        end
        wr_pulse_d = commit ? w_hit : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q  <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            // NOTE: the register bank is flops, not RAM, so it can and must be reset element by element.
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            wr_pulse_q <= wr_pulse_d;
            case (w_state_q)
                W_IDLE: begin
                    if (commit) begin
                        for (int i = 0; i < NUM_REGS; i++)
                            for (int b = 0; b < STRB_W; b++)
                                if (w_hit[i] && w_strb_q[b]) regs_q[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
                        bresp_q   <= (|w_hit) ? RESP_OKAY : RESP_SLVERR;
                        bvalid_q  <= 1'b1;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        w_state_q <= W_RESP;
                    end else begin
                        if (s.awvalid && !aw_held_q) begin
                            aw_addr_q <= s.awaddr;
                            aw_held_q <= 1'b1;
                        end
                        if (s.wvalid && !w_held_q) begin
                            w_data_q <= s.wdata;
                            w_strb_q <= s.wstrb;
                            w_held_q <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s.bready) begin
                        bvalid_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Read data is captured on the AR handshake, so a same-edge commit is not visible to it.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (s.arvalid) begin
                        rdata_q   <= rdata_d;
                        rresp_q   <= rresp_d;
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s.rready) begin
                        rvalid_q  <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign s.awready = (w_state_q == W_IDLE) && !aw_held_q;
    assign s.wready  = (w_state_q == W_IDLE) && !w_held_q;
    assign s.bvalid  = bvalid_q;
    assign s.bresp   = bresp_q;
    assign s.arready = (r_state_q == R_IDLE);
    assign s.rvalid  = rvalid_q;
    assign s.rresp   = rresp_q;
    assign s.rdata   = rdata_q;
    assign wr_pulse  = wr_pulse_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: directed vector table, multi-cycle corner
// sequences and random traffic checked against an array-based register model.
module tb_axi_lite_regfile;
    localparam int              AW  = 32;
    localparam int              DW  = 32;
    localparam int              NR  = 16;
    localparam logic [NR-1:0]   RO  = 16'h0088;
    localparam logic [NR*DW-1:0] RST = (512'hA5A5_0000 << 32) | (512'h5555_AAAA << 96)
                                     | (512'h0000_1111 << 192);

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [NR*DW-1:0]  reg_out;
    logic [NR*DW-1:0]  hw_in;
    logic [NR-1:0]     wr_pulse;

    axi_lite_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    axi_lite_regfile #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(RST)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .s        (bus),
        .reg_out  (reg_out),
        .hw_in    (hw_in),
        .wr_pulse (wr_pulse)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [NR];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < NR; i++) model[i] = RST[i*32 +: 32];
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb, output logic [15:0] pulse);
        int idx = int'(addr / 4);
        pulse = '0;
        if (idx >= NR || RO[idx]) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
        pulse[idx] = 1'b1;
        return 2'b00;
    endfunction

    function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                       output logic [1:0] resp);
        int idx = int'(addr / 4);
        if (idx >= NR) begin
            data = 0;
            resp = 2'b10;
        end else begin
            data = RO[idx] ? hw_in[idx*32 +: 32] : model[idx];
            resp = 2'b00;
        end
    endfunction

    function automatic logic [NR*DW-1:0] model_reg_out();
        logic [NR*DW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*32 +: 32] = RO[i] ? 32'h0 : model[i];
        return r;
    endfunction

    // ---------------- bus tasks ----------------
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output int lat, output logic [15:0] pulse);
        int cyc = 0;
        bit aw_done = 0, w_done = 0, awf, wf;
        bus.awaddr = addr;
        bus.wdata  = data;
        bus.wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            bus.awvalid = !aw_done && cyc >= aw_dly;
            bus.wvalid  = !w_done && cyc >= w_dly;
            awf = bus.awvalid && bus.awready;
            wf  = bus.wvalid && bus.wready;
            tick();
            cyc++;
            if (awf) aw_done = 1;
            if (wf) w_done = 1;
        end
        bus.awvalid = 0;
        bus.wvalid  = 0;
        check("aw_w_handshake", aw_done && w_done, 1);
        lat = 0;
        while (!bus.bvalid && lat < 20) begin
            tick();
            lat++;
        end
        resp  = bus.bresp;
        pulse = wr_pulse;
        if (bus.bready) tick();
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        int cyc = 0;
        bit fired = 0, f;
        bus.araddr = addr;
        while (!fired && cyc < 50) begin
            bus.arvalid = 1;
            f = bus.arready;
            tick();
            cyc++;
            if (f) fired = 1;
        end
        bus.arvalid = 0;
        check("ar_handshake", fired, 1);
        lat = 0;
        while (!bus.rvalid && lat < 20) begin
            tick();
            lat++;
        end
        data = bus.rdata;
        resp = bus.rresp;
        if (bus.rready) tick();
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic [15:0] exp_pulse;
    } vec_t;

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [14];
        logic [1:0]  resp, mresp;
        logic [31:0] rdat, mdat, wd;
        logic [15:0] pulse, mpulse;
        int          lat;

        vecs[0]  = '{0, 32'h04, 32'h0,         4'h0, 0, 0, 2'b00, 32'hA5A5_0000, 16'h0};
        vecs[1]  = '{1, 32'h08, 32'h1234_5678, 4'h5, 0, 3, 2'b00, 32'h0,         16'h0004};
        vecs[2]  = '{0, 32'h08, 32'h0,         4'h0, 0, 0, 2'b00, 32'h0034_0078, 16'h0};
        vecs[3]  = '{1, 32'h08, 32'h0,         4'hF, 0, 0, 2'b00, 32'h0,         16'h0004};
        vecs[4]  = '{1, 32'h08, 32'h1234_5678, 4'h5, 3, 0, 2'b00, 32'h0,         16'h0004};
        vecs[5]  = '{0, 32'h08, 32'h0,         4'h0, 0, 0, 2'b00, 32'h0034_0078, 16'h0};
        vecs[6]  = '{1, 32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b10, 32'h0,         16'h0};
        vecs[7]  = '{0, 32'h40, 32'h0,         4'h0, 0, 0, 2'b10, 32'h0,         16'h0};
        vecs[8]  = '{1, 32'h0C, 32'h1111_1111, 4'hF, 1, 0, 2'b10, 32'h0,         16'h0};
        vecs[9]  = '{0, 32'h0C, 32'h0,         4'h0, 0, 0, 2'b00, 32'hDEAD_BEEF, 16'h0};
        vecs[10] = '{1, 32'h19, 32'hFFFF_FFFF, 4'h8, 0, 0, 2'b00, 32'h0,         16'h0040};
        vecs[11] = '{0, 32'h18, 32'h0,         4'h0, 0, 0, 2'b00, 32'hFF00_1111, 16'h0};
        vecs[12] = '{1, 32'h14, 32'hFFFF_FFFF, 4'h0, 2, 2, 2'b00, 32'h0,         16'h0020};
        vecs[13] = '{0, 32'h14, 32'h0,         4'h0, 0, 0, 2'b00, 32'h0,         16'h0};

        hw_in = '0;
        hw_in[3*32 +: 32] = 32'hDEAD_BEEF;
        hw_in[7*32 +: 32] = $urandom;
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
        bus.bready = 1; bus.araddr = '0; bus.arvalid = 0; bus.rready = 1;
        model_reset();

        // Reset state
        repeat (3) tick();
        areset = 0;
        tick();
        check("rst_awready", bus.awready, 1);
        check("rst_wready", bus.wready, 1);
        check("rst_arready", bus.arready, 1);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_bresp_rresp", {bus.bresp, bus.rresp}, 0);
        check("rst_wr_pulse", wr_pulse, 0);
        check("rst_reg1", reg_out[1*32 +: 32], 32'hA5A5_0000);
        check("rst_ro_reg3_zero", reg_out[3*32 +: 32], 0);

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly,
                          resp, lat, pulse);
                mresp = model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, mpulse);
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
                check($sformatf("vec%0d_blat", i), lat, 1);
                check($sformatf("vec%0d_pulse", i), pulse, vecs[i].exp_pulse);
                check($sformatf("vec%0d_pulse_gone", i), wr_pulse, 0);
                check($sformatf("vec%0d_reg_out", i), reg_out, model_reg_out());
            end else begin
                axi_read(vecs[i].addr, rdat, resp, lat);
                check($sformatf("vec%0d_rdata", i), rdat, vecs[i].exp_rdata);
                check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
                check($sformatf("vec%0d_rlat", i), lat, 0);
            end
        end

        // Backpressure on both response channels
        bus.bready = 0;
        bus.rready = 0;
        wd = $urandom;
        axi_write(32'h10, wd, 4'hF, 0, 0, resp, lat, pulse);
        mresp = model_write(32'h10, wd, 4'hF, mpulse);
        axi_read(32'h04, rdat, resp, lat);
        for (int c = 0; c < 5; c++) begin
            check("bp_bvalid", bus.bvalid, 1);
            check("bp_bresp", bus.bresp, 2'b00);
            check("bp_rvalid", bus.rvalid, 1);
            check("bp_rdata_rresp", {bus.rdata, bus.rresp}, {32'hA5A5_0000, 2'b00});
            check("bp_readys", {bus.awready, bus.wready, bus.arready}, 3'b000);
            tick();
        end
        bus.bready = 1;
        bus.rready = 1;
        tick();
        check("bp_release_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        check("bp_release_readys", {bus.awready, bus.wready, bus.arready}, 3'b111);
        check("bp_reg_out", reg_out, model_reg_out());

        // Same-edge AR and commit on register 5
        axi_write(32'h14, 32'h1, 4'hF, 0, 0, resp, lat, pulse);
        mresp = model_write(32'h14, 32'h1, 4'hF, mpulse);
        bus.awaddr = 32'h14; bus.wdata = 32'h2; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1;
        tick();
        bus.awvalid = 0; bus.wvalid = 0;
        bus.araddr = 32'h14; bus.arvalid = 1;
        tick();
        bus.arvalid = 0;
        check("same_edge_bvalid", bus.bvalid, 1);
        check("same_edge_rvalid", bus.rvalid, 1);
        check("same_edge_old_value", bus.rdata, 32'h1);
        tick();
        mresp = model_write(32'h14, 32'h2, 4'hF, mpulse);
        axi_read(32'h14, rdat, resp, lat);
        check("same_edge_new_value", rdat, 32'h2);

        // Reset while a write response is pending
        bus.bready = 0;
        axi_write(32'h24, 32'hCAFE_F00D, 4'hF, 0, 0, resp, lat, pulse);
        mresp = model_write(32'h24, 32'hCAFE_F00D, 4'hF, mpulse);
        check("pre_reset_reg9", reg_out[9*32 +: 32], 32'hCAFE_F00D);
        areset = 1;
        tick();
        model_reset();
        check("mid_reset_bvalid", bus.bvalid, 0);
        check("mid_reset_reg_out", reg_out, model_reg_out());
        areset = 0;
        bus.bready = 1;
        tick();
        check("post_reset_readys", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // Random traffic against the model
        for (int n = 0; n < 150; n++) begin
            logic [31:0] addr;
            addr = $urandom_range(0, 19) * 4 + $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                logic [3:0] strb;
                wd   = $urandom;
                strb = 4'($urandom_range(0, 15));
                axi_write(addr, wd, strb, $urandom_range(0, 3), $urandom_range(0, 3), resp, lat, pulse);
                mresp = model_write(addr, wd, strb, mpulse);
                check($sformatf("rnd%0d_bresp", n), resp, mresp);
                check($sformatf("rnd%0d_pulse", n), pulse, mpulse);
                check($sformatf("rnd%0d_reg_out", n), reg_out, model_reg_out());
            end else begin
                axi_read(addr, rdat, resp, lat);
                model_read(addr, mdat, mresp);
                check($sformatf("rnd%0d_rdata_rresp", n), {rdat, resp}, {mdat, mresp});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
